// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: FSM state encoding and
// the width helper for lane-count counters.
package systolic_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD_W      = 3'd1,
    SWITCH_WAIT = 3'd2,
    STREAM      = 3'd3,
    DRAIN       = 3'd4,
    DONE        = 3'd5
  } state_t;

  localparam int MAX_N = 16;

  // A counter that must hold the value n (not just n-1) needs this many bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: DEPTH-stage shift register carrying {valid, data} together,
// with a synchronous clear that empties every stage.
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              shift_valid,
  input  logic [DATA_W-1:0] shift_data,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data
);

  logic [DATA_W:0] stage_r [DEPTH];

  // Shift one stage per cycle; clear drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= {shift_valid, shift_data};
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign {tap_valid, tap_data} = stage_r[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: sequences one tile into an NxN systolic array (skewed weight
// load, switch pulse, skewed input stream). Optional: SYSTOLIC_FEEDER_TRANSPOSE_EN.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic                cmd_load_w_in,
  input  logic [CNT_W-1:0]    cmd_num_rows_in,
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
  input  logic                cmd_transpose_in,
`endif
  input  logic [N*DATA_W-1:0] w_data_in,
  input  logic                w_valid_in,
  output logic                w_ready_out,
  input  logic [N*DATA_W-1:0] x_data_in,
  input  logic                x_valid_in,
  output logic                x_ready_out,
  output logic [N*DATA_W-1:0] sys_weight_out,
  output logic [N-1:0]        sys_accept_w_out,
  output logic                sys_switch_out,
  output logic [N*DATA_W-1:0] sys_data_out,
  output logic [N-1:0]        sys_start_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam int CW = cnt_width(N);

  state_t              state_r;
  logic [CNT_W-1:0]    m_r;
  logic [CNT_W-1:0]    x_cnt_r;
  logic [CW-1:0]       w_cnt_r;
  logic [CW-1:0]       wait_cnt_r;
  logic                sys_switch_r;
  logic                done_r;
  logic                w_accept_s;
  logic                x_accept_s;
  logic                w_lane_valid_s;
  logic [N*DATA_W-1:0] w_lane_data_s;
  logic [N*DATA_W-1:0] x_lane_data_s;

  assign cmd_ready_out  = (state_r == IDLE);
  assign busy_out       = (state_r != IDLE);
  assign w_ready_out    = (state_r == LOAD_W) && (w_cnt_r < CW'(N));
  assign x_ready_out    = (state_r == STREAM) && (x_cnt_r < m_r);
  assign w_accept_s     = w_valid_in && w_ready_out;
  assign x_accept_s     = x_valid_in && x_ready_out;
  assign sys_switch_out = sys_switch_r;
  assign done_out       = done_r;

`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
  logic                tp_r;
  logic                tp_emit_s;
  logic [N*DATA_W-1:0] tile_r [N];
  logic [N*DATA_W-1:0] col_s;

  // Emission runs once all N rows sit in the tile; wait_cnt_r picks the column.
  assign tp_emit_s = (state_r == LOAD_W) && tp_r && (w_cnt_r == CW'(N));

  // Column c of the captured tile: lane j carries tile row j, element c.
  always_comb begin
    col_s = '0;
    for (int c = 0; c < N; c++) begin
      for (int j = 0; j < N; j++) begin
        col_s[j*DATA_W +: DATA_W] = (wait_cnt_r == CW'(c)) ?
            tile_r[j][c*DATA_W +: DATA_W] : col_s[j*DATA_W +: DATA_W];
      end
    end
  end

  // Capture accepted weight rows into the tile while transposing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        tile_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        if (w_accept_s && tp_r && (w_cnt_r == CW'(r))) begin
          tile_r[r] <= w_data_in;
        end
      end
    end
  end

  assign w_lane_valid_s = tp_r ? tp_emit_s : w_accept_s;
  assign w_lane_data_s  = tp_r ? (tp_emit_s ? col_s : '0)
                               : (w_accept_s ? w_data_in : '0);
`else
  assign w_lane_valid_s = w_accept_s;
  assign w_lane_data_s  = w_accept_s ? w_data_in : '0;
`endif

  // Bubbles enter the skew lines as zero data so idle lanes stay quiet.
  assign x_lane_data_s = x_accept_s ? x_data_in : '0;

  // Tile sequencer: all state, counters and the switch/done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      m_r          <= '0;
      x_cnt_r      <= '0;
      w_cnt_r      <= '0;
      wait_cnt_r   <= '0;
      sys_switch_r <= 1'b0;
      done_r       <= 1'b0;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
      tp_r         <= 1'b0;
`endif
    end else begin
      sys_switch_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid_in) begin
            m_r        <= cmd_num_rows_in;
            x_cnt_r    <= '0;
            w_cnt_r    <= '0;
            wait_cnt_r <= '0;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
            tp_r       <= cmd_transpose_in;
`endif
            if (cmd_load_w_in) begin
              state_r <= LOAD_W;
            end else if (cmd_num_rows_in != '0) begin
              state_r <= STREAM;
            end else begin
              state_r <= DONE;
            end
          end
        end
        LOAD_W: begin
          if (w_accept_s) begin
            w_cnt_r <= w_cnt_r + CW'(1);
          end
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
          if (tp_r) begin
            if (tp_emit_s) begin
              if (wait_cnt_r == CW'(N - 1)) begin
                wait_cnt_r <= '0;
                state_r    <= SWITCH_WAIT;
              end else begin
                wait_cnt_r <= wait_cnt_r + CW'(1);
              end
            end
          end else if (w_accept_s && (w_cnt_r == CW'(N - 1))) begin
            state_r <= SWITCH_WAIT;
          end
`else
          if (w_accept_s && (w_cnt_r == CW'(N - 1))) begin
            state_r <= SWITCH_WAIT;
          end
`endif
        end
        SWITCH_WAIT: begin
          // N cycles after the last weight beat, lane N-1 has drained.
          if (sys_switch_r) begin
            wait_cnt_r <= '0;
            state_r    <= (m_r != '0) ? STREAM : DONE;
          end else if (wait_cnt_r == CW'(N - 1)) begin
            sys_switch_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        STREAM: begin
          if (x_accept_s) begin
            x_cnt_r <= x_cnt_r + CNT_W'(1);
            if (x_cnt_r == (m_r - CNT_W'(1))) begin
              wait_cnt_r <= '0;
              state_r    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wait_cnt_r == CW'(N - 1)) begin
            state_r <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Lane k of each side is delayed k+1 cycles to form the diagonal wavefront.
  for (genvar k = 0; k < N; k++) begin : g_lane
    skew_line #(.DEPTH(k + 1), .DATA_W(DATA_W)) u_w_skew (
      .clk         (clk),
      .clr         (rst),
      .shift_valid (w_lane_valid_s),
      .shift_data  (w_lane_data_s[k*DATA_W +: DATA_W]),
      .tap_valid   (sys_accept_w_out[k]),
      .tap_data    (sys_weight_out[k*DATA_W +: DATA_W])
    );
    skew_line #(.DEPTH(k + 1), .DATA_W(DATA_W)) u_x_skew (
      .clk         (clk),
      .clr         (rst),
      .shift_valid (x_accept_s),
      .shift_data  (x_lane_data_s[k*DATA_W +: DATA_W]),
      .tap_valid   (sys_start_out[k]),
      .tap_data    (sys_data_out[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed table-driven bench for systolic_feeder (N=2, DATA_W=16), plus hand
// sequences for mid-tile reset and, when enabled, the transpose option.
module tb_systolic_feeder;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load_w;
  logic [15:0] cmd_num_rows;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] sys_weight;
  logic [1:0]  sys_accept_w;
  logic        sys_switch;
  logic [31:0] sys_data;
  logic [1:0]  sys_start;
  logic        busy;
  logic        done;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
  logic        cmd_transpose;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  systolic_feeder #(.N(2), .DATA_W(16), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid_in     (cmd_valid),
    .cmd_ready_out    (cmd_ready),
    .cmd_load_w_in    (cmd_load_w),
    .cmd_num_rows_in  (cmd_num_rows),
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
    .cmd_transpose_in (cmd_transpose),
`endif
    .w_data_in        (w_data),
    .w_valid_in       (w_valid),
    .w_ready_out      (w_ready),
    .x_data_in        (x_data),
    .x_valid_in       (x_valid),
    .x_ready_out      (x_ready),
    .sys_weight_out   (sys_weight),
    .sys_accept_w_out (sys_accept_w),
    .sys_switch_out   (sys_switch),
    .sys_data_out     (sys_data),
    .sys_start_out    (sys_start),
    .busy_out         (busy),
    .done_out         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        cr;
    logic        wr;
    logic        xr;
    logic        busy;
    logic        done;
    logic        sw;
    logic [1:0]  acc;
    logic [31:0] wt;
    logic [1:0]  st;
    logic [31:0] dat;
  } obs_t;

  typedef struct {
    logic        cv;
    logic        lw;
    logic [15:0] m;
    logic        wv;
    logic [31:0] wd;
    logic        xv;
    logic [31:0] xd;
    obs_t        e;
  } vec_t;

  vec_t vq[$];

  function automatic obs_t ob(input logic cr, input logic wr, input logic xr,
                              input logic b, input logic d, input logic sw,
                              input logic [1:0] acc, input logic [31:0] wt,
                              input logic [1:0] st, input logic [31:0] dat);
    obs_t r;
    r.cr = cr; r.wr = wr; r.xr = xr; r.busy = b; r.done = d; r.sw = sw;
    r.acc = acc; r.wt = wt; r.st = st; r.dat = dat;
    return r;
  endfunction

  function automatic obs_t get_obs();
    return ob(cmd_ready, w_ready, x_ready, busy, done, sys_switch,
              sys_accept_w, sys_weight, sys_start, sys_data);
  endfunction

  task automatic add(input logic cv, input logic lw, input logic [15:0] m,
                     input logic wv, input logic [31:0] wd,
                     input logic xv, input logic [31:0] xd, input obs_t e);
    vec_t v;
    v.cv = cv; v.lw = lw; v.m = m; v.wv = wv; v.wd = wd; v.xv = xv; v.xd = xd; v.e = e;
    vq.push_back(v);
  endtask

  task automatic drive(input logic cv, input logic lw, input logic [15:0] m,
                       input logic wv, input logic [31:0] wd,
                       input logic xv, input logic [31:0] xd);
    cmd_valid = cv; cmd_load_w = lw; cmd_num_rows = m;
    w_valid = wv; w_data = wd; x_valid = xv; x_data = xd;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
    cmd_transpose = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  obs_t Z;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        quiet;
    logic        seen_done;
    int          cyc;
    int          lat;
    logic [15:0] l0;
    logic [15:0] l1;

    Z = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    #3 chk_obs("reset_state", get_obs(),
               ob(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0));
    rst = 1'b0;

    // Tile 1: load_w=1, M=2, weights {1,2},{3,4}, inputs {5,6},{7,8}.
    add(1'b1, 1'b1, 16'd2, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b1, 32'h0002_0001, 1'b0, 32'h0, ob(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b1, 32'h0004_0003, 1'b0, 32'h0, ob(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01,32'h0000_0001,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b11,32'h0002_0003,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b1, 32'h0063_0063, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,32'h0004_0000,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b1, 32'h0006_0005, ob(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b1, 32'h0008_0007, ob(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,32'h0,2'b01,32'h0000_0005));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,2'b11,32'h0006_0007));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,2'b10,32'h0008_0000));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,32'h0,2'b00,32'h0));
    // Tile 2: load_w=1, M=0, one-cycle w_valid bubble, stray command mid-tile.
    add(1'b1, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b1, 32'h000A_0009, 1'b0, 32'h0, ob(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b1, 1'b0, 16'd5, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01,32'h0000_0009,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b1, 32'h000C_000B, 1'b0, 32'h0, ob(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b10,32'h000A_0000,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,32'h0000_000B,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,32'h000C_0000,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,32'h0,2'b00,32'h0));
    // Tile 3: load_w=0, M=0 -> done two cycles after the handshake.
    add(1'b1, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,32'h0,2'b00,32'h0));
    add(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0, ob(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,2'b00,32'h0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].cv, vq[i].lw, vq[i].m, vq[i].wv, vq[i].wd, vq[i].xv, vq[i].xd);
      #3 chk_obs($sformatf("vec%0d", i), get_obs(), vq[i].e);
      @(posedge clk);
      #1;
    end

    // Abort: reset during STREAM after 1 of 3 rows.
    drive(1'b1, 1'b0, 16'd3, 1'b0, 32'h0, 1'b0, 32'h0);
    #3 chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b1, 32'h0002_0001);
    #3 chk("abort_x_ready", 32'(x_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    #3 chk("abort_first_row", {30'd0, sys_start}, 32'd1);
    step();
    rst = 1'b0;
    #3 chk_obs("abort_reset_state", get_obs(),
               ob(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0));
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      #3;
      if (done || (sys_start != 2'b00) || busy) quiet = 1'b0;
    end
    chk("abort_no_done_no_residue", 32'(quiet), 32'd1);

    // Fresh tile after abort: load_w=0, M=1, row {21,22}.
    step();
    drive(1'b1, 1'b0, 16'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b1, 32'h0016_0015);
    cyc = 1;
    lat = 0;
    seen_done = 1'b0;
    l0 = 16'd0;
    l1 = 16'd0;
    for (int k = 0; k < 20 && !seen_done; k++) begin
      #3;
      if (sys_start[0]) l0 = sys_data[15:0];
      if (sys_start[1]) l1 = sys_data[31:16];
      if (done) begin
        seen_done = 1'b1;
        lat = cyc;
      end else begin
        step();
        cyc++;
        x_valid = 1'b0;
      end
    end
    chk("fresh_done_seen", 32'(seen_done), 32'd1);
    chk("fresh_done_latency", 32'(lat), 32'd5);
    chk("fresh_lane0", 32'(l0), 32'd21);
    chk("fresh_lane1", 32'(l1), 32'd22);
    step();

`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
    // Transpose: tile {1,2},{3,4} -> emitted rows {1,3} then {2,4}.
    drive(1'b1, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    cmd_transpose = 1'b1;
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b1, 32'h0002_0001, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b1, 32'h0004_0003, 1'b0, 32'h0);
    #3 chk("tp_no_raw_pass", {30'd0, sys_accept_w}, 32'd0);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    #3 chk("tp_c0_lane0", {sys_accept_w, 14'd0, sys_weight[15:0]}, {2'b01, 14'd0, 16'd1});
    step();
    #3 chk("tp_c0l1_c1l0", sys_weight, 32'h0003_0002);
    step();
    #3 chk("tp_c1_lane1", {sys_accept_w, 14'd0, sys_weight[31:16]}, {2'b10, 14'd0, 16'd4});
    step();
    #3 chk("tp_switch", 32'(sys_switch), 32'd1);
    repeat (2) step();
    #3 chk("tp_done", 32'(done), 32'd1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Parametrised N×N successor of the fixed 2×2 UB-to-array hookup.
- Sequences one tile: loads N weight rows with per-column skew, pulses switch, then streams M input rows with per-row diagonal skew.
- Sits between the unified buffer read ports and the systolic array. Drives sys weight/accept_w, sys data/start and sys_switch.

Parameters:
- N, 2, array dimension (lanes per side), 1..16
- DATA_W, 16, lane data width (fixed-point)
- CNT_W, 16, width of the row-count field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid_in  in  1  tile command valid
- cmd_ready_out  out  1  high only in IDLE
- cmd_load_w_in  in  1  1 = run the weight-load phase before streaming
- cmd_num_rows_in  in  CNT_W  input rows to stream (M)
- w_data_in  in  N*DATA_W  one weight row; lane j = bits [j*DATA_W +: DATA_W]
- w_valid_in  in  1  weight row valid
- w_ready_out  out  1  weight row accepted when valid&&ready
- x_data_in  in  N*DATA_W  one input row
- x_valid_in  in  1  input row valid
- x_ready_out  out  1  input row accepted when valid&&ready
- sys_weight_out  out  N*DATA_W  to array top, column j
- sys_accept_w_out  out  N  per-column accept_w
- sys_switch_out  out  1  shadow→active pulse
- sys_data_out  out  N*DATA_W  to array left, row i
- sys_start_out  out  N  per-row start/valid
- busy_out  out  1  state != IDLE
- done_out  out  1  one-cycle pulse at tile end

Behaviour:
- Reset (synchronous):
  - state=IDLE; all outputs 0 except cmd_ready_out=1.
  - Skew registers cleared; no residual valid bits emitted.
  - rst mid-tile aborts immediately with no done pulse.
- Skew: lane k is registered k+1 cycles (lane 0 = 1 cycle, lane N-1 = N cycles). Data and valid travel together.
- FSM:
  - IDLE: on cmd_valid_in, latch M. If cmd_load_w_in → LOAD_W; else if M>0 → STREAM; else → DONE.
  - LOAD_W: w_ready_out=1 until N rows are accepted. w_valid low inserts a bubble, with accept_w low in that slot on every lane. After the Nth acceptance → SWITCH_WAIT.
  - SWITCH_WAIT: wait until the weight skew line is empty (last row out of lane N-1). Then assert sys_switch_out for exactly 1 cycle. Next state is STREAM if M>0, else DONE.
  - STREAM: x_ready_out=1 while the accepted count < M. Bubbles propagate as start=0 across all lanes. After the Mth acceptance → DRAIN.
  - DRAIN: wait N cycles until the x skew line is empty → DONE.
  - DONE: done_out=1 for 1 cycle → IDLE.
- Ready signals are combinational from state and counters only, never from valid.
- Counters saturate at target; cmd fields are ignored outside IDLE.
- M=0 with load_w=0: done_out is asserted 2 cycles after the command handshake.
- Switch timing: with weights accepted back-to-back from cycle t0, sys_switch_out is high at cycle t0+2N.
- The array's ≥1-cycle ordering constraint between switch and the first start is met, because x acceptance begins the cycle after the switch.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_TRANSPOSE_EN.
- With it defined:
  - cmd_transpose_in (1 bit, latched in IDLE) is added.
  - When set, LOAD_W captures the N rows into an N×N register tile, then emits column c of the tile as weight row c over N further cycles before SWITCH_WAIT.
  - Weight phase latency grows by N cycles.
- Without it: the port is absent and rows pass straight into the skew line.

Decomposition:
- Package systolic_feeder_pkg:
  - state_t enum (IDLE, LOAD_W, SWITCH_WAIT, STREAM, DRAIN, DONE)
  - localparam helper for counter width $clog2(N+1)
- Sub-module skew_line (params DEPTH, DATA_W): a shift register carrying {valid, data}, with synchronous clear.
  - Instantiated 2N times (N weight lanes, N input lanes), with DEPTH=k+1.

Test Plan:
- N=2, load_w=1, M=2:
  - Stimulus: weights {1,2} then {3,4} back-to-back; x {5,6},{7,8}.
  - Lane 0 weights appear on cycles t0+1 and t0+2; lane 1 on t0+2 and t0+3.
  - Switch pulses once at t0+4.
  - start[0] is high for 2 cycles, and start[1] repeats it one cycle later.
  - done follows.
- Bubble: w_valid low for 1 cycle between rows → accept_w shows a matching 1-cycle gap on both lanes, skewed. Switch is delayed by exactly 1 cycle.
- M=0, load_w=0 → no sys outputs toggle; done_out pulses 2 cycles after the handshake; cmd_ready returns high.
- M=0, load_w=1 → switch pulses; no start asserted; done follows.
- rst asserted during STREAM after 1 of 3 rows → next cycle all outputs 0, cmd_ready=1, no done. A fresh tile then runs correctly.
- With TRANSPOSE_EN, N=2, tile {1,2},{3,4}, transpose=1 → emitted weight rows are {1,3} then {2,4}.
